// File: rtl/my8_io_if.sv
// Multiplexed 8-bit address/data bus between a core (master) and my8_io (slave).
// The shared adbus net is resolved here from each side's output enable and data.
interface my8_io_if;
  logic       bus_do;   // address-phase strobe; "do" itself is a reserved word
  logic       rW;
  logic       m_oe;
  logic [7:0] m_dout;
  logic       s_oe;
  logic [7:0] s_dout;
  wire  [7:0] adbus;

  // Slave owns the bus only in its read data phase; nobody driving leaves it floating.
  assign adbus = s_oe ? s_dout : (m_oe ? m_dout : 8'hzz);

  modport master (output bus_do, rW, m_oe, m_dout, input s_oe, adbus);
  modport slave  (input bus_do, rW, adbus, output s_oe, s_dout);
endinterface

// File: rtl/my8_io.sv
// Memory-mapped I/O block: switch synchronizer, LED register and a reload timer
// with wrap status and interrupt, behind an 8-register window at BASE.
module my8_io #(
  parameter logic [7:0] BASE        = 8'hF0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       m_clock,
  input  logic       p_reset,
  my8_io_if.slave    bus,
  input  logic [7:0] sw_byte,
  output logic [7:0] led_out,
  output logic       irq
);
  typedef enum logic [1:0] {IDLE, DATA_RD, DATA_WR} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  led_q, led_d, cnt_q, cnt_d, reload_q, reload_d;
  logic                        en_q, en_d, ie_q, ie_d, wrap_q, wrap_d, irq_q, irq_d;
  logic                        wr, wrap_set;
  logic [7:0]                  wdat, rd_data;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      sync_q   <= '0;
      led_q    <= 8'h00;
      cnt_q    <= 8'h00;
      reload_q <= 8'h00;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      wrap_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_byte};
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      wrap_q   <= wrap_d;
      irq_q    <= irq_d;
    end
  end

  // Transactions are only accepted from IDLE; a strobe during a data phase is ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.bus_do && bus.adbus[7:3] == BASE[7:3]) begin
          idx_d   = bus.adbus[2:0];
          state_d = bus.rW ? DATA_RD : DATA_WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (idx_q)
      3'd0:    rd_data = sync_q[SYNC_STAGES-1];
      3'd1:    rd_data = led_q;
      3'd2:    rd_data = cnt_q;
      3'd3:    rd_data = reload_q;
      3'd4:    rd_data = {6'd0, ie_q, en_q};
      3'd5:    rd_data = {7'd0, wrap_q};
      default: rd_data = 8'h00;
    endcase
  end

  assign bus.s_oe   = (state_q == DATA_RD);
  assign bus.s_dout = rd_data;
  assign wr         = (state_q == DATA_WR);
  assign wdat       = bus.adbus;

  // A RELOAD write preempts the timer for that edge; a wrap beats a same-edge W1C.
  always_comb begin
    led_d    = led_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    ie_d     = ie_q;
    wrap_set = 1'b0;
    if (wr && idx_q == 3'd3) begin
      reload_d = wdat;
      cnt_d    = wdat;
    end else if (en_q) begin
      if (cnt_q == 8'd0) begin
        cnt_d    = reload_q;
        wrap_set = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
    if (wr && idx_q == 3'd1) led_d = wdat;
    if (wr && idx_q == 3'd4) begin
      en_d = wdat[0];
      ie_d = wdat[1];
    end
    wrap_d = wrap_set | (wrap_q & ~(wr && idx_q == 3'd5 && wdat[0]));
    irq_d  = wrap_d & ie_d;
  end

  assign led_out = led_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_my8_io.sv
// Bench for my8_io: directed scenarios plus randomized bus traffic checked
// against a register-level reference model of the I/O block.
module tb_my8_io;
  localparam logic [7:0] BASE = 8'hF0;
  localparam int         SS   = 2;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic [7:0] sw_byte = 8'h00;
  logic [7:0] led_out;
  logic       irq;
  int         passed = 0;
  int         total  = 0;

  logic [7:0] m_led, m_cnt, m_reload;
  logic       m_en, m_ie, m_wrap, m_irq;
  logic [7:0] m_sw[$];

  my8_io_if bif();
  my8_io #(.BASE(BASE), .SYNC_STAGES(SS)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .bus(bif.slave),
    .sw_byte(sw_byte), .led_out(led_out), .irq(irq)
  );

  always #5 m_clock = ~m_clock;

  function automatic bit in_win(input logic [7:0] a);
    return a[7:3] == BASE[7:3];
  endfunction

  function automatic void m_reset();
    m_led = 8'h00; m_cnt = 8'h00; m_reload = 8'h00;
    m_en = 1'b0; m_ie = 1'b0; m_wrap = 1'b0; m_irq = 1'b0;
    m_sw.delete();
    for (int i = 0; i < SS; i++) m_sw.push_back(8'h00);
  endfunction

  // One clock edge of the register file; wr marks a data-phase write landing on it.
  function automatic void m_step(input bit wr, input logic [2:0] idx, input logic [7:0] d);
    bit set;
    set = 1'b0;
    m_sw.push_back(sw_byte);
    void'(m_sw.pop_front());
    if (wr && idx == 3'd3) begin
      m_reload = d; m_cnt = d;
    end else if (m_en) begin
      if (m_cnt == 8'd0) begin m_cnt = m_reload; set = 1'b1; end
      else m_cnt = m_cnt - 8'd1;
    end
    if (wr && idx == 3'd5 && d[0]) m_wrap = 1'b0;
    if (set) m_wrap = 1'b1;
    if (wr && idx == 3'd1) m_led = d;
    if (wr && idx == 3'd4) begin m_en = d[0]; m_ie = d[1]; end
    m_irq = m_wrap & m_ie;
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return m_sw[0];
      3'd1:    return m_led;
      3'd2:    return m_cnt;
      3'd3:    return m_reload;
      3'd4:    return {6'd0, m_ie, m_en};
      3'd5:    return {7'd0, m_wrap};
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick(input bit wr, input logic [2:0] idx, input logic [7:0] d);
    @(posedge m_clock);
    m_step(wr, idx, d);
    #1;
  endtask

  task automatic wr_bus(input logic [7:0] a, input logic [7:0] d, input bit noise);
    bif.bus_do = 1'b1; bif.rW = 1'b0; bif.m_oe = 1'b1; bif.m_dout = a;
    tick(1'b0, 3'd0, 8'h00);
    bif.bus_do = noise; bif.m_dout = d;
    tick(in_win(a), a[2:0], d);
    bif.bus_do = 1'b0; bif.m_oe = 1'b0;
  endtask

  task automatic rd_bus(input logic [7:0] a, input bit noise,
                        output logic oe, output logic [7:0] v, output logic [7:0] e);
    bif.bus_do = 1'b1; bif.rW = 1'b1; bif.m_oe = 1'b1; bif.m_dout = a;
    tick(1'b0, 3'd0, 8'h00);
    bif.m_oe = 1'b0; bif.bus_do = noise; bif.m_dout = 8'hF3;
    #1;
    oe = bif.s_oe; v = bif.adbus; e = m_read(a[2:0]);
    tick(1'b0, 3'd0, 8'h00);
    bif.bus_do = 1'b0;
  endtask

  task automatic test_reset();
    logic oe; logic [7:0] v, e, a;
    bif.bus_do = 1'b0; bif.rW = 1'b0; bif.m_oe = 1'b0; bif.m_dout = 8'h00;
    p_reset = 1'b1; sw_byte = 8'h5A;
    repeat (3) @(posedge m_clock);
    #1;
    total++; if (led_out !== 8'h00) $display("FAIL reset_led got %h want 00", led_out); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
    total++; if (bif.s_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", bif.s_oe); else passed++;
    p_reset = 1'b0; m_reset();
    for (int i = 2; i <= 5; i++) begin
      a = BASE + 8'(i);
      rd_bus(a, 1'b0, oe, v, e);
      total++; if (oe !== 1'b1 || v !== 8'h00) $display("FAIL reset_reg%0d got oe=%b %h want oe=1 00", i, oe, v); else passed++;
    end
    rd_bus(BASE, 1'b0, oe, v, e);
    total++; if (v !== 8'h5A) $display("FAIL reset_sw_sync got %h want 5a", v); else passed++;
  endtask

  task automatic test_led_rw();
    logic oe; logic [7:0] v, e;
    wr_bus(8'hF1, 8'hA5, 1'b0);
    total++; if (led_out !== 8'hA5) $display("FAIL led_out got %h want a5", led_out); else passed++;
    total++; if (bif.s_oe !== 1'b0) $display("FAIL led_pre_oe got %b want 0", bif.s_oe); else passed++;
    rd_bus(8'hF1, 1'b0, oe, v, e);
    total++; if (oe !== 1'b1 || v !== 8'hA5) $display("FAIL led_read got oe=%b %h want oe=1 a5", oe, v); else passed++;
    total++; if (bif.s_oe !== 1'b0) $display("FAIL led_post_oe got %b want 0", bif.s_oe); else passed++;
  endtask

  task automatic test_switches();
    logic oe; logic [7:0] v, e;
    sw_byte = 8'h22;
    repeat (3) tick(1'b0, 3'd0, 8'h00);
    rd_bus(8'hF0, 1'b0, oe, v, e);
    total++; if (v !== 8'h22) $display("FAIL sw_read got %h want 22", v); else passed++;
    rd_bus(8'h10, 1'b0, oe, v, e);
    total++; if (oe !== 1'b0) $display("FAIL oow_read_oe got %b want 0", oe); else passed++;
    total++; if (bif.s_oe !== 1'b0) $display("FAIL oow_post_oe got %b want 0", bif.s_oe); else passed++;
    wr_bus(8'h10, 8'h77, 1'b0);
    wr_bus(8'hF6, 8'h55, 1'b0);
    total++; if (led_out !== 8'hA5) $display("FAIL oow_write_led got %h want a5", led_out); else passed++;
    rd_bus(8'hF6, 1'b0, oe, v, e);
    total++; if (oe !== 1'b1 || v !== 8'h00) $display("FAIL rsvd6 got oe=%b %h want oe=1 00", oe, v); else passed++;
    rd_bus(8'hF7, 1'b0, oe, v, e);
    total++; if (oe !== 1'b1 || v !== 8'h00) $display("FAIL rsvd7 got oe=%b %h want oe=1 00", oe, v); else passed++;
    rd_bus(8'hF1, 1'b0, oe, v, e);
    total++; if (v !== 8'hA5) $display("FAIL oow_led_kept got %h want a5", v); else passed++;
  endtask

  // CNT after CTRL enable: 3 -> 2 (first read) -> 1 -> 0 (second read) -> 3 with WRAP.
  task automatic test_timer();
    logic oe; logic [7:0] v, e;
    wr_bus(8'hF3, 8'h03, 1'b0);
    wr_bus(8'hF4, 8'h03, 1'b0);
    rd_bus(8'hF2, 1'b0, oe, v, e);
    total++; if (v !== 8'h02) $display("FAIL timer_cnt_a got %h want 02", v); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL timer_irq_pre got %b want 0", irq); else passed++;
    rd_bus(8'hF2, 1'b0, oe, v, e);
    total++; if (v !== 8'h00) $display("FAIL timer_cnt_b got %h want 00", v); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL timer_irq got %b want 1", irq); else passed++;
    rd_bus(8'hF5, 1'b0, oe, v, e);
    total++; if (v !== 8'h01) $display("FAIL timer_wrap got %h want 01", v); else passed++;
  endtask

  task automatic test_collision();
    logic oe; logic [7:0] v, e;
    for (int g = 0; g < 20 && m_cnt != 8'd1; g++) tick(1'b0, 3'd0, 8'h00);
    wr_bus(8'hF5, 8'h01, 1'b0);
    total++; if (irq !== 1'b1) $display("FAIL w1c_collide_irq got %b want 1", irq); else passed++;
    wr_bus(8'hF5, 8'h01, 1'b0);
    total++; if (irq !== 1'b0) $display("FAIL w1c_clear_irq got %b want 0", irq); else passed++;
    rd_bus(8'hF5, 1'b0, oe, v, e);
    total++; if (v !== 8'h00) $display("FAIL w1c_stat got %h want 00", v); else passed++;
    wr_bus(8'hF4, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    logic oe; logic [7:0] v, e;
    bif.bus_do = 1'b1; bif.rW = 1'b0; bif.m_oe = 1'b1; bif.m_dout = 8'hF1;
    tick(1'b0, 3'd0, 8'h00);
    bif.bus_do = 1'b0; bif.m_dout = 8'hFF; p_reset = 1'b1;
    #1;
    total++; if (led_out !== 8'h00) $display("FAIL midrst_led got %h want 00", led_out); else passed++;
    @(posedge m_clock);
    #1;
    p_reset = 1'b0; bif.m_oe = 1'b0; m_reset();
    wr_bus(8'hF1, 8'h3C, 1'b0);
    total++; if (led_out !== 8'h3C) $display("FAIL midrst_rewrite got %h want 3c", led_out); else passed++;
    rd_bus(8'hF4, 1'b0, oe, v, e);
    total++; if (v !== 8'h00) $display("FAIL midrst_ctrl got %h want 00", v); else passed++;
  endtask

  task automatic test_random();
    int op;
    bit nz;
    logic oe;
    logic [7:0] a, d, v, e;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      nz = ($urandom_range(0, 3) == 0);
      a  = BASE + 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      if (a[2:0] == 3'd3) d = 8'($urandom_range(0, 5));
      case (op)
        0, 1, 2, 3: wr_bus(a, d, nz);
        4, 5, 6: begin
          rd_bus(a, nz, oe, v, e);
          total++; if (oe !== 1'b1 || v !== e) $display("FAIL rnd_read n=%0d a=%h got oe=%b %h want oe=1 %h", n, a, oe, v, e); else passed++;
        end
        7: begin
          a = a ^ 8'h08;
          if ($urandom_range(0, 1) == 1) begin
            rd_bus(a, 1'b0, oe, v, e);
            total++; if (oe !== 1'b0) $display("FAIL rnd_oow_oe n=%0d a=%h got %b want 0", n, a, oe); else passed++;
          end else wr_bus(a, d, 1'b0);
        end
        8: repeat ($urandom_range(1, 3)) tick(1'b0, 3'd0, 8'h00);
        default: begin sw_byte = 8'($urandom); tick(1'b0, 3'd0, 8'h00); end
      endcase
      total++; if (led_out !== m_led) $display("FAIL rnd_led n=%0d got %h want %h", n, led_out, m_led); else passed++;
      total++; if (irq !== m_irq) $display("FAIL rnd_irq n=%0d got %b want %b", n, irq, m_irq); else passed++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_led_rw();
    test_switches();
    test_timer();
    test_collision();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d of %0d checks", passed, total);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/my8_io.md
MY8_IO -- requirements
Module: my8_io

Interface
REQ-001 The block SHALL have parameter BASE, default 8'hF0, meaning the I/O window base; the window is BASE..BASE+7 and BASE[2:0] SHALL be 0.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on sw_byte (legal 2..3).
REQ-003 m_clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 p_reset  input  1  reset, asynchronous, active-high.
REQ-005 do  input  1  bus strobe from the core; marks the address phase.
REQ-006 rW  input  1  bus direction sampled with the address: 1 = read, 0 = write.
REQ-007 adbus  inout  8  multiplexed address/data bus; the block SHALL drive it only during its own read data phase and SHALL hold it at high-Z otherwise.
REQ-008 sw_byte  input  8  asynchronous switch inputs.
REQ-009 led_out  output  8  LED register contents.
REQ-010 irq  output  1  timer interrupt request, level, registered.

Function
REQ-011 Bus FSM states: IDLE, DATA_RD, DATA_WR.
- IDLE: rising edge with do=1 and adbus[7:3]==BASE[7:3] latches adbus[2:0] as the register index.
- Same edge moves to DATA_RD if rW=1, DATA_WR if rW=0.
- Out-of-window address or do=0 stays in IDLE.
REQ-012 DATA_RD: adbus SHALL carry the selected register value for the whole cycle after the address edge; the FSM SHALL return to IDLE at the next edge (read latency 1 cycle).
REQ-013 DATA_WR: adbus SHALL be sampled at the next rising edge into the selected register; the FSM SHALL return to IDLE at that edge.
REQ-014 do asserted while in DATA_RD/DATA_WR SHALL be ignored; a new transaction SHALL be accepted only in IDLE.
REQ-015 Register map (index: name, access):
- 0: SW, RO, synchronized sw_byte.
- 1: LED, RW.
- 2: CNT, RO, timer count.
- 3: RELOAD, RW.
- 4: CTRL, RW, bit0 EN, bit1 IE, others 0.
- 5: STAT, bit0 WRAP, write-1-to-clear.
- 6-7: reserved, read 8'h00, writes ignored.
REQ-016 SW SHALL pass through SYNC_STAGES flops; a read SHALL return the last synchronizer stage.
REQ-017 led_out SHALL equal the LED register, updated on the DATA_WR edge.
REQ-018 Timer with EN=1: CNT SHALL decrement by 1 each cycle; when CNT==0, the next edge SHALL load CNT from RELOAD and set WRAP.
REQ-019 Timer with EN=0: CNT SHALL hold.
REQ-020 Writing RELOAD SHALL load both RELOAD and CNT on the same edge; this overrides any decrement or wrap reload in that cycle, and no WRAP is set in that cycle.
REQ-021 RELOAD=0 with EN=1: CNT SHALL stay 0 and WRAP SHALL set every cycle.
REQ-022 If a WRAP set and a W1C clear of WRAP occur on the same edge, the set SHALL win.
REQ-023 irq SHALL be a register updated each edge to WRAP_next & IE_next; it asserts the cycle after WRAP sets when IE=1.
REQ-024 A read of STAT in the same cycle as a wrap SHALL return the pre-edge WRAP value.
REQ-025 All arithmetic is 8-bit unsigned; CNT wraps only through reload, never by underflow.

Reset
REQ-026 p_reset=1 SHALL asynchronously force:
- FSM to IDLE, adbus to high-Z.
- led_out=8'h00, irq=0.
- CNT, RELOAD, CTRL, WRAP and the synchronizer flops to 0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no register write; the block SHALL accept a new address phase on the first edge after p_reset deasserts.
REQ-028 After reset release, SW SHALL reflect sw_byte within SYNC_STAGES edges.

Verification
REQ-029 Write then read: LED write 8'hA5 at 8'hF1 -> led_out=8'hA5 after the data edge; read of 8'hF1 drives adbus=8'hA5 in the data cycle, high-Z before and after.
REQ-030 Switches: sw_byte=8'h22, wait 3 cycles, read 8'hF0 -> adbus=8'h22; an access to address 8'h10 leaves adbus high-Z and registers unchanged.
REQ-031 Timer: write RELOAD=8'h03, CTRL=8'h03 -> CNT sequence 3,2,1,0,3; WRAP=1 on reload; irq=1 one cycle later.
REQ-032 WRAP set/clear collision: W1C write to STAT on the wrap edge -> WRAP stays 1; a W1C write one cycle later -> WRAP=0, irq=0 on the next edge.
REQ-033 Reset mid-write: assert p_reset during DATA_WR of LED=8'hFF -> led_out=8'h00 immediately; after release, a new write is accepted on the first edge.
